// File: rtl/bios_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : bios_cmd_if
// Purpose  : Request, byte-stream and response signals of bios_cmd_master.
// Revision : 1.0 - initial release
// ============================================================================
interface bios_cmd_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [2:0]            i_cmd_op;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [7:0]            i_cmd_data;
    logic [7:0]            o_data;
    logic                  o_valid;
    logic                  i_out_ready;
    logic [7:0]            i_data;
    logic                  i_valid;
    logic                  o_in_ready;
    logic                  o_rsp_valid;
    logic [7:0]            o_rsp_data;
    logic                  o_rsp_err;
    logic                  o_busy;
    logic                  o_booted;

    modport master (
        input  i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
        input  i_out_ready, i_data, i_valid,
        output o_cmd_ready, o_data, o_valid, o_in_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err, o_busy, o_booted
    );

    modport slave (
        output i_cmd_valid, i_cmd_op, i_cmd_addr, i_cmd_data,
        output i_out_ready, i_data, i_valid,
        input  o_cmd_ready, o_data, o_valid, o_in_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err, o_busy, o_booted
    );
endinterface
`default_nettype wire

// File: rtl/bios_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : bios_cmd_master
// Purpose  : Turns word requests into 4-byte BIOS command frames with an
//            address-half cache, and collects single-byte read responses.
// Revision : 1.0 - initial release
// ============================================================================
module bios_cmd_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int RSP_TIMEOUT = 1024
) (
    input  wire logic  clk,
    input  wire logic  rst,
    bios_cmd_if.master bus
);
    localparam int                 c_TMO_W    = $clog2(RSP_TIMEOUT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(RSP_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SEND   = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;
    localparam logic [1:0] c_ST_BOOTED = 2'd3;

    localparam logic [2:0] c_OP_NOP   = 3'd0;
    localparam logic [2:0] c_OP_BOOT  = 3'd1;
    localparam logic [2:0] c_OP_RST   = 3'd2;
    localparam logic [2:0] c_OP_ADRL  = 3'd3;
    localparam logic [2:0] c_OP_ADRH  = 3'd4;
    localparam logic [2:0] c_OP_WRITE = 3'd5;
    localparam logic [2:0] c_OP_READ  = 3'd6;

    function automatic logic [2:0] f_map_op(input logic [2:0] op);
        logic [2:0] m;
        case (op)
            3'd1:    m = c_OP_BOOT;
            3'd2:    m = c_OP_RST;
            3'd3:    m = c_OP_WRITE;
            3'd4:    m = c_OP_READ;
            default: m = c_OP_NOP;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] f_frame_byte(input logic [2:0]  op,
                                                input logic [1:0]  idx,
                                                input logic [31:0] addr,
                                                input logic [7:0]  wdata);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 2'd0) begin
            b = {5'b0, op};
        end else if (op == c_OP_ADRL) begin
            if (idx == 2'd1)      b = addr[7:0];
            else if (idx == 2'd2) b = addr[15:8];
        end else if (op == c_OP_ADRH) begin
            if (idx == 2'd1)      b = addr[23:16];
            else if (idx == 2'd2) b = addr[31:24];
        end else if (op == c_OP_WRITE && idx == 2'd1) begin
            b = wdata;
        end
        return b;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               pend_lo_q, pend_lo_d;
    logic               pend_hi_q, pend_hi_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic [c_TMO_W-1:0] tmo_q, tmo_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic               booted_q, booted_d;
    logic               lo_vld_q, lo_vld_d;
    logic [15:0]        lo_q, lo_d;
    logic               hi_vld_q, hi_vld_d;
    logic [15:0]        hi_q, hi_d;
    logic               alive_q;

    logic [31:0] w_cmd_addr32;
    logic        w_cmd_ready;
    logic        w_accept;
    logic        w_fire;
    logic        w_last;
    logic [2:0]  w_mop;
    logic        w_is_mem;
    logic        w_lo_miss;
    logic        w_hi_miss;
    logic [2:0]  w_cur_op;
    logic [2:0]  w_first_op;
    logic        w_tmo_hit;

    generate
        if (ADDR_WIDTH < 32) begin : g_addr_pad
            assign w_cmd_addr32 = {{(32-ADDR_WIDTH){1'b0}}, bus.i_cmd_addr};
        end else begin : g_addr_full
            assign w_cmd_addr32 = bus.i_cmd_addr[31:0];
        end
    endgenerate

    assign w_accept   = bus.i_cmd_valid & w_cmd_ready;
    assign w_fire     = valid_q & bus.i_out_ready;
    assign w_last     = (state_q == c_ST_SEND) & w_fire & (idx_q == 2'd3) & ~pend_lo_q & ~pend_hi_q;
    assign w_mop      = f_map_op(bus.i_cmd_op);
    assign w_is_mem   = (w_mop == c_OP_WRITE) | (w_mop == c_OP_READ);
    assign w_lo_miss  = w_is_mem & (~lo_vld_q | (lo_q != w_cmd_addr32[15:0]));
    assign w_hi_miss  = w_is_mem & (~hi_vld_q | (hi_q != w_cmd_addr32[31:16]));
    // Pending address frames always go out before the final command frame.
    assign w_cur_op   = pend_lo_q ? c_OP_ADRL : (pend_hi_q ? c_OP_ADRH : op_q);
    assign w_first_op = w_lo_miss ? c_OP_ADRL : (w_hi_miss ? c_OP_ADRH : w_mop);
    assign w_tmo_hit  = (tmo_q == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= c_ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_accept) state_d = c_ST_SEND;
            c_ST_SEND: begin
                if (w_last) begin
                    if (op_q == c_OP_READ)      state_d = c_ST_WAIT;
                    else if (op_q == c_OP_BOOT) state_d = c_ST_BOOTED;
                    else                        state_d = c_ST_IDLE;
                end
            end
            c_ST_WAIT: if (bus.i_valid || w_tmo_hit) state_d = c_ST_IDLE;
            default:   state_d = c_ST_BOOTED;
        endcase
    end

    always_comb begin
        w_cmd_ready = alive_q & (state_q == c_ST_IDLE);
        bus.o_busy  = (state_q == c_ST_SEND) | (state_q == c_ST_WAIT);
    end

    assign bus.o_cmd_ready = w_cmd_ready;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_in_ready  = alive_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_booted    = booted_q;

    always_comb begin
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pend_lo_d   = pend_lo_q;
        pend_hi_d   = pend_hi_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        tmo_d       = tmo_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        booted_d    = booted_q;
        lo_vld_d    = lo_vld_q;
        lo_d        = lo_q;
        hi_vld_d    = hi_vld_q;
        hi_d        = hi_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    op_d      = w_mop;
                    addr_d    = w_cmd_addr32;
                    wdata_d   = bus.i_cmd_data;
                    pend_lo_d = w_lo_miss;
                    pend_hi_d = w_hi_miss;
                    idx_d     = 2'd0;
                    valid_d   = 1'b1;
                    data_d    = f_frame_byte(w_first_op, 2'd0, w_cmd_addr32, bus.i_cmd_data);
                end
            end
            c_ST_SEND: begin
                if (w_fire) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (pend_lo_q) begin
                            lo_vld_d  = 1'b1;
                            lo_d      = addr_q[15:0];
                            pend_lo_d = 1'b0;
                            data_d    = {5'b0, (pend_hi_q ? c_OP_ADRH : op_q)};
                        end else if (pend_hi_q) begin
                            hi_vld_d  = 1'b1;
                            hi_d      = addr_q[31:16];
                            pend_hi_d = 1'b0;
                            data_d    = {5'b0, op_q};
                        end else begin
                            valid_d = 1'b0;
                            data_d  = 8'h00;
                            tmo_d   = '0;
                            if (op_q == c_OP_BOOT) booted_d = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        data_d = f_frame_byte(w_cur_op, idx_q + 2'd1, addr_q, wdata_q);
                    end
                end
            end
            c_ST_WAIT: begin
                // A byte landing on the timeout cycle still counts as a response.
                if (bus.i_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.i_data;
                    rsp_err_d   = 1'b0;
                end else if (w_tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 8'h00;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + c_TMO_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= c_OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            pend_lo_q   <= 1'b0;
            pend_hi_q   <= 1'b0;
            idx_q       <= 2'd0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            booted_q    <= 1'b0;
            lo_vld_q    <= 1'b0;
            lo_q        <= '0;
            hi_vld_q    <= 1'b0;
            hi_q        <= '0;
            alive_q     <= 1'b0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pend_lo_q   <= pend_lo_d;
            pend_hi_q   <= pend_hi_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            booted_q    <= booted_d;
            lo_vld_q    <= lo_vld_d;
            lo_q        <= lo_d;
            hi_vld_q    <= hi_vld_d;
            hi_q        <= hi_d;
            alive_q     <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bios_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_bios_cmd_master
// Purpose  : Directed and randomized checks of bios_cmd_master against a
//            frame-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bios_cmd_master;
    localparam int c_AW  = 32;
    localparam int c_TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bios_cmd_if #(.ADDR_WIDTH(c_AW)) bus ();
    bios_cmd_master #(.ADDR_WIDTH(c_AW), .RSP_TIMEOUT(c_TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_vec = 0;
    int         n_miss = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         cyc = 0, first_hs = 0, last_hs = 0, exp_n = 0;
    bit         stall_mode = 0, noise_en = 0, pstall = 0;
    logic [7:0] pdata;
    int         resp_at = 0;
    logic [7:0] resp_byte;
    int         rsp_cnt = 0, rsp_cyc = 0;
    logic [7:0] rsp_d;
    logic       rsp_e;
    bit         m_lo_v, m_hi_v;
    logic [15:0] m_lo, m_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] outs();
        return {9'b0, bus.o_cmd_ready, bus.o_data, bus.o_valid, bus.o_in_ready, bus.o_rsp_valid,
                bus.o_rsp_data, bus.o_rsp_err, bus.o_busy, bus.o_booted};
    endfunction

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
    endtask

    // Reference: which frames a request produces given the cached address halves.
    task automatic model_req(input logic [2:0] op, input logic [31:0] a, input logic [7:0] d);
        exp_q.delete();
        case (op)
            3'd1: push4(8'h01, 8'h00, 8'h00, 8'h00);
            3'd2: push4(8'h02, 8'h00, 8'h00, 8'h00);
            3'd3, 3'd4: begin
                if (!m_lo_v || m_lo != a[15:0]) begin
                    push4(8'h03, a[7:0], a[15:8], 8'h00);
                    m_lo_v = 1; m_lo = a[15:0];
                end
                if (!m_hi_v || m_hi != a[31:16]) begin
                    push4(8'h04, a[23:16], a[31:24], 8'h00);
                    m_hi_v = 1; m_hi = a[31:16];
                end
                if (op == 3'd3) push4(8'h05, d, 8'h00, 8'h00);
                else            push4(8'h06, 8'h00, 8'h00, 8'h00);
            end
            default: push4(8'h00, 8'h00, 8'h00, 8'h00);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_rsp_valid) begin
            rsp_cnt++; rsp_cyc = cyc; rsp_d = bus.o_rsp_data; rsp_e = bus.o_rsp_err;
        end
        if (pstall) begin
            check("stall_valid", 32'(bus.o_valid), 32'd1);
            check("stall_data", 32'(bus.o_data), 32'(pdata));
        end
        bus.i_out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.o_valid && bus.i_out_ready) begin
            if (got_q.size() == 0) first_hs = cyc + 1;
            got_q.push_back(bus.o_data);
            last_hs = cyc + 1;
        end
        pstall = bus.o_valid && !bus.i_out_ready;
        pdata  = bus.o_data;
        if (resp_at != 0) begin
            bus.i_valid = (cyc + 1 == resp_at);
            bus.i_data  = resp_byte;
        end else begin
            bus.i_valid = noise_en && (int'(got_q.size()) < exp_n) && ($urandom_range(0, 1) == 1);
            bus.i_data  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_cmd_valid = 0; bus.i_cmd_op = 0; bus.i_cmd_addr = 0; bus.i_cmd_data = 0;
        bus.i_out_ready = 0; bus.i_valid = 0; bus.i_data = 0;
        resp_at = 0; exp_n = 0; pstall = 0; stall_mode = 0; noise_en = 0;
        m_lo_v = 0; m_hi_v = 0;
        repeat (3) @(posedge clk);
        #1 check("reset_outs", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("in_ready", 32'(bus.o_in_ready), 32'd1);
        check("idle_ready", 32'(bus.o_cmd_ready), 32'd1);
    endtask

    task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [7:0] d,
                          input bit stall, input int rdly);
        int t;
        int rsp0;
        int ec;
        logic [7:0] ed;
        logic ee;
        model_req(op, a, d);
        exp_n = exp_q.size();
        got_q.delete();
        resp_at = 0;
        stall_mode = stall;
        rsp0 = rsp_cnt;
        t = 0;
        while (!bus.o_cmd_ready && t < 50) begin tick(); t++; end
        check("cmd_ready", 32'(bus.o_cmd_ready), 32'd1);
        bus.i_cmd_valid = 1; bus.i_cmd_op = op; bus.i_cmd_addr = a; bus.i_cmd_data = d;
        tick();
        bus.i_cmd_valid = 0;
        check("first_valid", 32'(bus.o_valid), 32'd1);
        check("busy_send", 32'(bus.o_busy), 32'd1);
        t = 0;
        while (int'(got_q.size()) < exp_n && t < 500) begin tick(); t++; end
        check("byte_count", 32'(got_q.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < int'(got_q.size()); i++)
            check($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        if (!stall) check("contiguous", 32'(last_hs - first_hs), 32'(exp_n - 1));
        tick();
        check("valid_drop", 32'(bus.o_valid), 32'd0);
        if (op == 3'd4) begin
            check("busy_wait", 32'(bus.o_busy), 32'd1);
            resp_byte = 8'($urandom);
            resp_at = (rdly > 0) ? last_hs + rdly : 0;
            bus.i_valid = (resp_at != 0) && (cyc + 1 == resp_at);
            bus.i_data = resp_byte;
            if (rdly >= 1 && rdly <= c_TMO) begin ed = resp_byte; ee = 0; ec = rdly; end
            else begin ed = 8'h00; ee = 1; ec = c_TMO; end
            t = 0;
            while (rsp_cnt == rsp0 && t < c_TMO + 10) begin tick(); t++; end
            check("rsp_seen", 32'(rsp_cnt - rsp0), 32'd1);
            check("rsp_data", 32'(rsp_d), 32'(ed));
            check("rsp_err", 32'(rsp_e), 32'(ee));
            check("rsp_latency", 32'(rsp_cyc - last_hs), 32'(ec));
            tick();
            check("rsp_single", 32'(rsp_cnt - rsp0), 32'd1);
            check("rsp_hold", 32'(bus.o_rsp_data), 32'(ed));
        end else begin
            check("no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        end
        if (op == 3'd1) begin
            check("booted", 32'(bus.o_booted), 32'd1);
            check("booted_ready", 32'(bus.o_cmd_ready), 32'd0);
            check("booted_busy", 32'(bus.o_busy), 32'd0);
        end else begin
            check("idle_busy", 32'(bus.o_busy), 32'd0);
            check("idle_ready_after", 32'(bus.o_cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] his[2];
        logic [15:0] los[3];
        int cnt;
        int t;
        logic [2:0] op;
        his[0] = 16'h0001; his[1] = 16'h8000;
        los[0] = 16'h2345; los[1] = 16'h2346; los[2] = 16'hFFFF;

        do_reset();
        do_req(3'd3, 32'h0001_2345, 8'hA5, 0, 0);
        do_req(3'd3, 32'h0001_2346, 8'h11, 0, 0);
        do_req(3'd3, 32'h0001_2346, 8'h22, 0, 0);
        do_req(3'd4, 32'h0001_2346, 8'h00, 0, 10);
        do_req(3'd4, 32'h0001_2346, 8'h00, 0, 0);
        do_req(3'd0, 32'h0000_0000, 8'h00, 0, 0);

        do_reset();
        do_req(3'd3, 32'h0001_2345, 8'hA5, 1, 0);
        do_req(3'd4, 32'h0001_2345, 8'h00, 0, 16);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7));
            if (op == 3'd1) op = 3'd4;
            noise_en = ($urandom_range(0, 1) == 1);
            do_req(op, {his[$urandom_range(0, 1)], los[$urandom_range(0, 2)]}, 8'($urandom),
                   ($urandom_range(0, 1) == 1), $urandom_range(0, 18));
        end
        noise_en = 0;

        do_req(3'd1, 32'h0000_0000, 8'h00, 0, 0);
        bus.i_cmd_valid = 1; bus.i_cmd_op = 3'd3;
        noise_en = 1; exp_n = 1 << 20; resp_at = 0;
        cnt = 0;
        repeat (100) begin
            tick();
            if (bus.o_cmd_ready || bus.o_valid || bus.o_rsp_valid) cnt++;
        end
        bus.i_cmd_valid = 0;
        check("boot_lock", 32'(cnt), 32'd0);
        check("booted_sticky", 32'(bus.o_booted), 32'd1);

        do_reset();
        got_q.delete(); exp_n = 12;
        bus.i_cmd_valid = 1; bus.i_cmd_op = 3'd3; bus.i_cmd_addr = 32'h0001_2345; bus.i_cmd_data = 8'h3C;
        tick();
        bus.i_cmd_valid = 0;
        t = 0;
        while (got_q.size() < 5 && t < 50) begin tick(); t++; end
        check("pre_abort_bytes", 32'(got_q.size()), 32'd5);
        #2 rst = 1'b1;
        #1 check("rst_async_outs", outs(), 32'd0);
        do_reset();
        do_req(3'd3, 32'h0001_2345, 8'h77, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire
